// File: rtl/param_ram.sv
// Single-port parameterized RAM with byte enables, a registered read pipeline of
// RD_LAT stages, and a full-memory zero sweep after reset or on a clr pulse.
module param_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                wen,
  input  logic                clr,
  input  logic [DATA_W/8-1:0] s_be,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W-1:0]   s_din,
  output logic [DATA_W-1:0]   s_dout,
  output logic                s_rvalid,
  output logic                busy
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, INIT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              rd_acc, wr_acc;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT:1]             vld_pipe;
  logic [RD_LAT:1][DATA_W-1:0] dat_pipe;

  // clr wins over a same-edge request, so the request is simply not accepted
  assign rd_acc = (state == IDLE) && cen && !wen && !clr;
  assign wr_acc = (state == IDLE) && cen && wen && !clr && (|s_be);
  assign busy   = (state == INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_n = INIT;
          ptr_n   = '0;
        end
      end
      INIT: begin
        ptr_n = ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) state_n = IDLE;
      end
      default: begin
        state_n = INIT;
        ptr_n   = '0;
      end
    endcase
  end

  // Array is not reset; the INIT sweep zeroes it once rst is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[ptr] <= '0;
      end else if (wr_acc) begin
        for (int k = 0; k < NB; k++)
          if (s_be[k]) mem[s_addr][8*k +: 8] <= s_din[8*k +: 8];
      end
    end
  end

  // Data stages carry zero when invalid so s_dout is zero whenever s_rvalid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      dat_pipe[1] <= rd_acc ? mem[s_addr] : '0;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign s_rvalid = vld_pipe[RD_LAT];
  assign s_dout   = dat_pipe[RD_LAT];

endmodule

// File: tb/tb_param_ram.sv
// Bench for param_ram: drives RD_LAT=1 and RD_LAT=2 instances in lockstep and
// checks both against a per-edge memory/response-queue model plus directed vectors.
module tb_param_ram;
  logic        clk, rst, cen, wen, clr;
  logic [7:0]  s_be, s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout1, s_dout2;
  logic        s_rvalid1, s_rvalid2, busy1, busy2;

  param_ram #(.DATA_W(64), .ADDR_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .clr(clr), .s_be(s_be),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout1), .s_rvalid(s_rvalid1), .busy(busy1));
  param_ram #(.DATA_W(64), .ADDR_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .clr(clr), .s_be(s_be),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout2), .s_rvalid(s_rvalid2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] d; } rsp_t;
  typedef struct {
    logic wen; logic [7:0] be; logic [7:0] addr; logic [63:0] din; logic [63:0] exp;
  } vec_t;

  int          checks = 0, errors = 0;
  int          n_edge = 0, clear_left = 0;
  logic [63:0] mem_m [256];
  rsp_t        q1[$], q2[$];
  logic        o1v, o2v;
  logic [63:0] o1d, o2d;
  vec_t        vt [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_rsp(inout rsp_t q[$], output logic v, output logic [63:0] d);
    v = 1'b0; d = '0;
    if (q.size() > 0 && q[0].due == n_edge) begin
      v = 1'b1; d = q[0].d; void'(q.pop_front());
    end
  endtask

  // One clock edge: drive, apply the model's rules for that edge, compare both DUTs.
  task automatic cyc(input logic c, input logic w, input logic cl, input logic [7:0] be,
                     input logic [7:0] a, input logic [63:0] d);
    logic        ev;
    logic [63:0] ed;
    cen = c; wen = w; clr = cl; s_be = be; s_addr = a; s_din = d;
    @(posedge clk);
    n_edge++;
    if (clear_left > 0) begin
      mem_m[256 - clear_left] = '0;
      clear_left--;
    end else if (cl) begin
      clear_left = 256;
    end else if (c && w) begin
      for (int k = 0; k < 8; k++) if (be[k]) mem_m[a][8*k +: 8] = d[8*k +: 8];
    end else if (c) begin
      q1.push_back('{n_edge, mem_m[a]});
      q2.push_back('{n_edge + 1, mem_m[a]});
    end
    #1;
    o1v = s_rvalid1; o1d = s_dout1; o2v = s_rvalid2; o2d = s_dout2;
    chk("busy1", {63'd0, busy1}, {63'd0, clear_left > 0});
    chk("busy2", {63'd0, busy2}, {63'd0, clear_left > 0});
    exp_rsp(q1, ev, ed);
    chk("rvalid1", {63'd0, o1v}, {63'd0, ev});
    chk("dout1", o1d, ed);
    exp_rsp(q2, ev, ed);
    chk("rvalid2", {63'd0, o2v}, {63'd0, ev});
    chk("dout2", o2d, ed);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy1 && n < 400) begin idle(); n++; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy1", {63'd0, busy1}, 64'd1);
    chk("rst_busy2", {63'd0, busy2}, 64'd1);
    chk("rst_rvalid", {62'd0, s_rvalid1, s_rvalid2}, 64'd0);
    chk("rst_dout1", s_dout1, 64'd0);
    chk("rst_dout2", s_dout2, 64'd0);
    #1;
    rst = 1'b0;
    clear_left = 256;
    q1.delete(); q2.delete();
  endtask

  initial begin
    int n;
    vt[0]  = '{1'b1, 8'hFF, 8'h10, 64'h1122334455667788, 64'h0};
    vt[1]  = '{1'b1, 8'h0F, 8'h10, 64'hAAAAAAAAAAAAAAAA, 64'h0};
    vt[2]  = '{1'b0, 8'h00, 8'h10, 64'h0, 64'h11223344AAAAAAAA};
    vt[3]  = '{1'b1, 8'hFF, 8'h01, 64'hA, 64'h0};
    vt[4]  = '{1'b1, 8'hFF, 8'h02, 64'hB, 64'h0};
    vt[5]  = '{1'b1, 8'hFF, 8'h03, 64'hC, 64'h0};
    vt[6]  = '{1'b1, 8'h00, 8'h04, 64'hFFFFFFFFFFFFFFFF, 64'h0};
    vt[7]  = '{1'b0, 8'hFF, 8'h04, 64'h0, 64'h0};
    vt[8]  = '{1'b0, 8'h00, 8'hFF, 64'h0, 64'h0};
    vt[9]  = '{1'b1, 8'h81, 8'h05, 64'hFFEEDDCCBBAA9988, 64'h0};
    vt[10] = '{1'b0, 8'h00, 8'h05, 64'h0, 64'hFF00000000000088};
    for (int i = 0; i < 256; i++) mem_m[i] = '0;

    rst = 1'b1; cen = 0; wen = 0; clr = 0; s_be = 0; s_addr = 0; s_din = 0;
    #2;
    chk("por_busy", {63'd0, busy1 & busy2}, 64'd1);
    chk("por_rvalid", {62'd0, s_rvalid1, s_rvalid2}, 64'd0);
    chk("por_dout", s_dout1 | s_dout2, 64'd0);
    #10;
    rst = 1'b0;
    clear_left = 256;
    wait_busy(n);
    chk("por_busy_cycles", n, 256);

    // Directed vectors: reads checked at latency 1 then latency 2.
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, vt[i].wen, 1'b0, vt[i].be, vt[i].addr, vt[i].din);
      if (!vt[i].wen) begin
        chk($sformatf("vec%0d_v1", i), {63'd0, o1v}, 64'd1);
        chk($sformatf("vec%0d_d1", i), o1d, vt[i].exp);
        idle();
        chk($sformatf("vec%0d_v2", i), {63'd0, o2v}, 64'd1);
        chk($sformatf("vec%0d_d2", i), o2d, vt[i].exp);
      end
    end

    // Back-to-back reads, in-order at both latencies.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 64'h0);
    chk("b2b_1a", o1d, 64'hA);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 64'h0);
    chk("b2b_1b", o1d, 64'hB); chk("b2b_2a", o2d, 64'hA);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 64'h0);
    chk("b2b_1c", o1d, 64'hC); chk("b2b_2b", o2d, 64'hB);
    idle();
    chk("b2b_1end", {63'd0, o1v}, 64'd0); chk("b2b_2c", o2d, 64'hC);
    idle();

    // Read immediately after write to the same address.
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 8'h30, 64'h77);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h30, 64'h0);
    chk("raw_d1", o1d, 64'h77);
    idle();

    // Write during a clear, after the sweep has passed its address.
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 8'h20, 64'h99);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 64'h0);
    n = 0;
    while (busy1 && n < 400) begin
      if (n == 100) cyc(1'b1, 1'b1, 1'b0, 8'hFF, 8'h20, 64'h5);
      else idle();
      n++;
    end
    chk("clr_busy_cycles", n, 256);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 64'h0);
    chk("clr_rd_v", {63'd0, o1v}, 64'd1);
    chk("clr_rd_d", o1d, 64'h0);
    idle();

    // Read before clr is delivered; read on the clr edge is dropped.
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 8'h10, 64'h0102);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 64'h0);
    chk("pre_clr_d1", o1d, 64'h0102);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h10, 64'h0);
    chk("pre_clr_v2", {63'd0, o2v}, 64'd1);
    chk("pre_clr_d2", o2d, 64'h0102);
    chk("clr_edge_v1", {63'd0, o1v}, 64'd0);
    chk("clr_edge_busy", {63'd0, busy1}, 64'd1);
    idle();
    chk("clr_edge_v2", {63'd0, o2v}, 64'd0);
    wait_busy(n);
    chk("clr2_busy_cycles", n, 255);

    // Reset with a read in flight, then reset mid-sweep at ptr=100.
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 8'h11, 64'h55);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 64'h0);
    do_reset();
    for (int i = 0; i < 100; i++) idle();
    chk("mid_busy_pre", {63'd0, busy1}, 64'd1);
    do_reset();
    wait_busy(n);
    chk("mid_busy_cycles", n, 256);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic c, w, cl;
      c  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) != 0;
      cl = ($urandom_range(0, 299) == 0);
      cyc(c, w, cl, 8'($urandom), 8'($urandom_range(0, 15)),
          {32'($urandom), 32'($urandom)});
    end
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
